display_capture: RTL
====================

Name: display_capture

Overview:
- Receiving end of the multiplexed 7-segment display interface.
- Watches the `anode`/`segment` lines that the display driver produces and reconstructs the four BCD digits being shown.
- Publishes them as one coherent frame, with a pulse, a staleness flag and sticky protocol-error flags.
- Used on-chip for stopwatch self-check and as the bench-side monitor for display scan logic.

Parameters:
- STABLE_CYCLES, 4, consecutive identical input samples required before a digit is captured (legal range 2..255).
- TIMEOUT_CYCLES, 65536, clock cycles without a completed frame before `stale` asserts (legal range ≥ 4·STABLE_CYCLES).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- anode  input  4  digit enables, active-low; bit i selects digit i.
- segment  input  7  segment drives {g,f,e,d,c,b,a}, active-low.
- clr_err  input  1  synchronous clear of `err_pattern` and `err_multi`.
- d0  output  4  digit 0 of the last completed frame (BCD).
- d1  output  4  digit 1 of the last completed frame.
- d2  output  4  digit 2 of the last completed frame.
- d3  output  4  digit 3 of the last completed frame.
- frame_valid  output  1  one-cycle pulse when d0..d3 update.
- stale  output  1  high when no frame has completed for TIMEOUT_CYCLES cycles.
- err_pattern  output  1  sticky: a stable, non-blank, undecodable segment pattern was seen.
- err_multi  output  1  sticky: more than one anode was low for a stable dwell.

Behaviour:
- **Reset values:** d0..d3=0, frame_valid=0, stale=0, err_pattern=0, err_multi=0. Internal state also clears: sample register, stability counter, `armed`=1, `seen` mask=0, shadow digits=0, timeout counter=0. A reset mid-dwell or mid-frame discards all partial capture.
- **Input register:** `anode`/`segment` are registered once per clock. All decisions use registered values.
- **Stability counter:**
  - If the registered pair differs from the previous registered pair: counter←0, `armed`←1.
  - Otherwise the counter increments, saturating at STABLE_CYCLES-1.
- **Capture event:** fires when counter==STABLE_CYCLES-2 and the pair is still unchanged, and `armed`=1; then `armed`←0. Timing: a pair applied before edge E and held is acted on at edge E+STABLE_CYCLES. At most one capture per dwell.
- **Action at the capture event, by number of low anode bits:**
  - Zero low bits: no action (inter-digit blanking).
  - Two or more low bits: err_multi←1; no digit update.
  - Exactly one low bit, index i, segment 7'h7F (all off): no action (blank digit).
  - Exactly one low bit, index i, any other pattern: decode via the table below.
    - Match: shadow[i]←value, seen[i]←1.
    - No match: err_pattern←1, shadow[i] and seen[i] unchanged.
- **Decode table** (hex, active-low): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10. Nothing else is legal.
- **Frame completion:**
  - Condition: after the capture update, seen==4'b1111.
  - At that same edge: d0..d3←shadow (including the value just captured), frame_valid=1 for exactly one cycle, seen←0, timeout counter←0, stale←0.
  - Recapturing an already-seen index overwrites its shadow value and does not complete a frame early.
- **Timeout:**
  - The timeout counter increments every cycle without a frame completion, saturating at TIMEOUT_CYCLES-1.
  - stale←1 when it reaches TIMEOUT_CYCLES-1.
  - stale holds until the next frame completion.
  - seen is not cleared by timeout.
- **clr_err:** clears both sticky errors at that edge. If an error event occurs in the same cycle, the error wins and the flag stays 1.
- **Simultaneous events:** frame completion and timeout saturation in the same cycle → frame wins; stale=0 and the counter clears.
- **Outputs:** all outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- **Clean scan**, STABLE_CYCLES=4: reset, then drive anode 1110/seg 79, 1101/24, 1011/30, 0111/19, each for 8 cycles. Expect d0..d3=1,2,3,4; frame_valid a single pulse exactly 4 edges after the 0111 pair is applied; err flags remain 0.
- **Glitch rejection:** a 3-cycle dwell of 1110/02 inside a valid scan → no capture, no frame; a following 8-cycle 1110/40 dwell captures 0.
- **Protocol errors:**
  - anode 1100 stable 8 cycles → err_multi=1.
  - anode 1110/seg 7'h55 stable → err_pattern=1, d0 unchanged.
  - clr_err pulse → both flags 0.
  - Blank pattern 7'h7F stable → no error.
- **Timeout**, TIMEOUT_CYCLES=64: after one frame, hold anode 1111 → stale=1 at cycle 63 after frame_valid; a subsequent full scan clears stale on its frame_valid edge.
- **Reset mid-frame:** capture digits 0..2, assert rst one cycle, then capture digit 3 only → no frame_valid, d0..d3 remain 0.
- **Free-running scan:** run the team's display driver with changing digits for 10,000 cycles → every frame_valid shows d0..d3 matching the driver's digit inputs as sampled one scan period earlier.

Source files
------------

// File: rtl/display_capture.sv
`default_nettype none
// ============================================================================
//  Module      : display_capture
//  Description : Receiver for a multiplexed 4-digit 7-segment display bus.
//                Debounces each anode/segment dwell, decodes the BCD digit
//                shown and publishes complete 4-digit frames together with a
//                frame pulse, a staleness flag and sticky protocol errors.
//  Revision    : 1.0 - initial release
// ============================================================================
module display_capture #(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] anode,
    input  logic [6:0] segment,
    input  logic       clr_err,
    output logic [3:0] d0,
    output logic [3:0] d1,
    output logic [3:0] d2,
    output logic [3:0] d3,
    output logic       frame_valid,
    output logic       stale,
    output logic       err_pattern,
    output logic       err_multi
);

    localparam int              c_TW        = $clog2(TIMEOUT_CYCLES);
    localparam logic [7:0]      c_STAB_MAX  = 8'(STABLE_CYCLES - 1);
    localparam logic [7:0]      c_STAB_HIT  = 8'(STABLE_CYCLES - 2);
    localparam logic [c_TW-1:0] c_TO_MAX    = c_TW'(TIMEOUT_CYCLES - 1);
    localparam logic [c_TW-1:0] c_TO_PRE    = c_TW'(TIMEOUT_CYCLES - 2);
    localparam logic [6:0]      c_SEG_BLANK = 7'h7F;

    logic [3:0]      r_anode;
    logic [6:0]      r_seg;
    logic [3:0]      r_prev_anode;
    logic [6:0]      r_prev_seg;
    logic [7:0]      r_cnt;
    logic            r_armed;
    logic [3:0]      r_seen;
    logic [3:0][3:0] r_shadow;
    logic [c_TW-1:0] r_to_cnt;

    logic            w_same;
    logic            w_capture;
    logic [3:0]      w_low;
    logic            w_multi;
    logic            w_one_hot;
    logic [1:0]      w_idx;
    logic            w_dec_ok;
    logic [3:0]      w_dec_val;
    logic            w_digit_ok;
    logic            w_pat_err;
    logic            w_multi_err;
    logic [3:0]      w_seen_next;
    logic [3:0][3:0] w_shadow_next;
    logic            w_frame;

    // Sample the display bus once and keep the previous sample for comparison.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_anode      <= 4'd0;
            r_seg        <= 7'd0;
            r_prev_anode <= 4'd0;
            r_prev_seg   <= 7'd0;
        end else begin
            r_anode      <= anode;
            r_seg        <= segment;
            r_prev_anode <= r_anode;
            r_prev_seg   <= r_seg;
        end
    end

    assign w_same    = ({r_anode, r_seg} == {r_prev_anode, r_prev_seg});
    assign w_capture = w_same && r_armed && (r_cnt == c_STAB_HIT);

    // Dwell length counter; armed allows exactly one capture per dwell.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= 8'd0;
            r_armed <= 1'b1;
        end else if (!w_same) begin
            r_cnt   <= 8'd0;
            r_armed <= 1'b1;
        end else begin
            if (r_cnt != c_STAB_MAX) begin
                r_cnt <= r_cnt + 8'd1;
            end
            if (w_capture) begin
                r_armed <= 1'b0;
            end
        end
    end

    assign w_low     = ~r_anode;
    assign w_multi   = ((w_low & (w_low - 4'd1)) != 4'd0);
    assign w_one_hot = (w_low != 4'd0) && !w_multi;

    // Index of the selected digit (only meaningful when exactly one is low).
    always_comb begin
        w_idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (w_low[i]) begin
                w_idx = 2'(i);
            end
        end
    end

    // Active-low segment pattern to BCD; anything outside 0..9 is illegal.
    always_comb begin
        w_dec_ok  = 1'b1;
        w_dec_val = 4'd0;
        case (r_seg)
            7'h40:   w_dec_val = 4'd0;
            7'h79:   w_dec_val = 4'd1;
            7'h24:   w_dec_val = 4'd2;
            7'h30:   w_dec_val = 4'd3;
            7'h19:   w_dec_val = 4'd4;
            7'h12:   w_dec_val = 4'd5;
            7'h02:   w_dec_val = 4'd6;
            7'h78:   w_dec_val = 4'd7;
            7'h00:   w_dec_val = 4'd8;
            7'h10:   w_dec_val = 4'd9;
            default: w_dec_ok  = 1'b0;
        endcase
    end

    assign w_digit_ok  = w_capture && w_one_hot && (r_seg != c_SEG_BLANK) && w_dec_ok;
    assign w_pat_err   = w_capture && w_one_hot && (r_seg != c_SEG_BLANK) && !w_dec_ok;
    assign w_multi_err = w_capture && w_multi;

    // Shadow digits and seen mask as they stand after this cycle's capture.
    always_comb begin
        w_shadow_next = r_shadow;
        w_seen_next   = r_seen;
        if (w_digit_ok) begin
            w_shadow_next[w_idx] = w_dec_val;
            w_seen_next[w_idx]   = 1'b1;
        end
    end

    assign w_frame = (w_seen_next == 4'hF);

    // Accumulate digits and publish a frame once all four have been seen.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shadow    <= '0;
            r_seen      <= 4'd0;
            d0          <= 4'd0;
            d1          <= 4'd0;
            d2          <= 4'd0;
            d3          <= 4'd0;
            frame_valid <= 1'b0;
        end else begin
            r_shadow    <= w_shadow_next;
            frame_valid <= w_frame;
            if (w_frame) begin
                r_seen <= 4'd0;
                d0     <= w_shadow_next[0];
                d1     <= w_shadow_next[1];
                d2     <= w_shadow_next[2];
                d3     <= w_shadow_next[3];
            end else begin
                r_seen <= w_seen_next;
            end
        end
    end

    // Frame watchdog; a completed frame always overrides saturation.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_to_cnt <= '0;
            stale    <= 1'b0;
        end else if (w_frame) begin
            r_to_cnt <= '0;
            stale    <= 1'b0;
        end else if (r_to_cnt != c_TO_MAX) begin
            r_to_cnt <= r_to_cnt + c_TW'(1);
            if (r_to_cnt == c_TO_PRE) begin
                stale <= 1'b1;
            end
        end
    end

    // Sticky error flags; a new error in the clearing cycle keeps the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_pattern <= 1'b0;
            err_multi   <= 1'b0;
        end else begin
            err_pattern <= (err_pattern & ~clr_err) | w_pat_err;
            err_multi   <= (err_multi & ~clr_err) | w_multi_err;
        end
    end

endmodule
`default_nettype wire
